// File: rtl/clk_divider.sv
// Integer clock divider: registered near-50%-duty divided clock plus a
// one-cycle strobe in the CLK domain marking each rising edge of clk_div.
module clk_divider #(
  parameter int Time = 20
) (
  input  logic CLK,
  input  logic RST,
  output logic clk_div,
  output logic tick
);

  localparam int TIME_EFF = (Time < 2) ? 2 : Time;
  localparam int CW_RAW   = $clog2(TIME_EFF);
  localparam int CW       = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int LOW      = (TIME_EFF + 1) / 2;

  localparam logic [CW-1:0] LAST_C = CW'(TIME_EFF - 1);
  localparam logic [CW-1:0] LOW_C  = CW'(LOW);

  logic [CW-1:0] count_q, count_d;
  logic          clk_div_q, clk_div_d;
  logic          tick_q, tick_d;

  // Outputs are decoded from the next count so they are registered
  // in the same cycle the counter lands on the threshold.
  always_comb begin
    count_d   = (count_q == LAST_C) ? '0 : count_q + CW'(1);
    clk_div_d = (count_d >= LOW_C);
    tick_d    = (count_d == LOW_C);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q   <= '0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_div = clk_div_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_divider.sv
// Directed-vector bench for clk_divider at ratios 20, 5, 2 and 1 (clamped),
// with a running tick/clk_div relationship checker on the Time=20 instance.
module tb_clk_divider;

  logic CLK = 1'b0;
  logic RST;
  logic d20, t20, d5, t5, d2, t2, d1, t1;

  always #5 CLK = ~CLK;

  clk_divider #(.Time(20)) u20 (.CLK(CLK), .RST(RST), .clk_div(d20), .tick(t20));
  clk_divider #(.Time(5))  u5  (.CLK(CLK), .RST(RST), .clk_div(d5),  .tick(t5));
  clk_divider #(.Time(2))  u2  (.CLK(CLK), .RST(RST), .clk_div(d2),  .tick(t2));
  clk_divider #(.Time(1))  u1  (.CLK(CLK), .RST(RST), .clk_div(d1),  .tick(t1));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Edge k after reset release, expected {d20,t20,d5,t5,d2,t2}; Time=1 must match Time=2.
  typedef struct {
    int   k;
    logic e_d20, e_t20, e_d5, e_t5, e_d2, e_t2;
  } vec_t;

  vec_t vecs[20];

  // Running checker: tick never two cycles in a row, and tick implies a fresh rise.
  logic prev_t20 = 1'b0;
  logic prev_d20 = 1'b0;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      checks++;
      if ((t20 && prev_t20) || (t20 && !(d20 && !prev_d20))) begin
        failures++;
        $display("FAIL tick_rule: tick=%b prev_tick=%b clk_div=%b prev_clk_div=%b at t=%0t",
                 t20, prev_t20, d20, prev_d20, $time);
      end
      prev_t20 = t20;
      prev_d20 = d20;
    end
  end

  initial begin
    int edge_n;
    int ticks20;
    int highs20;

    vecs[0]  = '{1,   0,0, 0,0, 1,1};
    vecs[1]  = '{2,   0,0, 0,0, 0,0};
    vecs[2]  = '{3,   0,0, 1,1, 1,1};
    vecs[3]  = '{4,   0,0, 1,0, 0,0};
    vecs[4]  = '{5,   0,0, 0,0, 1,1};
    vecs[5]  = '{8,   0,0, 1,1, 0,0};
    vecs[6]  = '{9,   0,0, 1,0, 1,1};
    vecs[7]  = '{10,  1,1, 0,0, 0,0};
    vecs[8]  = '{11,  1,0, 0,0, 1,1};
    vecs[9]  = '{13,  1,0, 1,1, 1,1};
    vecs[10] = '{19,  1,0, 1,0, 1,1};
    vecs[11] = '{20,  0,0, 0,0, 0,0};
    vecs[12] = '{21,  0,0, 0,0, 1,1};
    vecs[13] = '{30,  1,1, 0,0, 0,0};
    vecs[14] = '{31,  1,0, 0,0, 1,1};
    vecs[15] = '{50,  1,1, 0,0, 0,0};
    vecs[16] = '{70,  1,1, 0,0, 0,0};
    vecs[17] = '{90,  1,1, 0,0, 0,0};
    vecs[18] = '{99,  1,0, 1,0, 1,1};
    vecs[19] = '{100, 0,0, 0,0, 0,0};

    // Reset held: all outputs low
    RST = 1'b1;
    repeat (5) begin
      @(posedge CLK);
      #1;
      chk("reset_hold", {d20, t20, d5, t5, d2, t2, d1, t1}, 8'h00);
    end

    @(negedge CLK);
    RST = 1'b0;
    edge_n  = 0;
    ticks20 = 0;
    highs20 = 0;

    for (int i = 0; i < 20; i++) begin
      while (edge_n < vecs[i].k) begin
        @(posedge CLK);
        #1;
        edge_n++;
        if (t20) ticks20++;
        if (d20) highs20++;
      end
      chk($sformatf("vec_k%0d_t20", vecs[i].k), {6'b0, d20, t20}, {6'b0, vecs[i].e_d20, vecs[i].e_t20});
      chk($sformatf("vec_k%0d_t5", vecs[i].k),  {6'b0, d5, t5},   {6'b0, vecs[i].e_d5, vecs[i].e_t5});
      chk($sformatf("vec_k%0d_t2", vecs[i].k),  {6'b0, d2, t2},   {6'b0, vecs[i].e_d2, vecs[i].e_t2});
      chk($sformatf("vec_k%0d_t1", vecs[i].k),  {6'b0, d1, t1},   {6'b0, vecs[i].e_d2, vecs[i].e_t2});
    end

    chk("tick_count_100", ticks20[7:0], 8'd5);
    chk("high_cycles_100", highs20[7:0], 8'd50);

    // Mid-period reset at count=14 with clk_div high
    while (edge_n < 114) begin
      @(posedge CLK);
      #1;
      edge_n++;
    end
    chk("pre_reset_high", {7'b0, d20}, 8'h01);
    #2;
    RST = 1'b1;
    #1;
    chk("async_clear", {d20, t20, d5, t5, d2, t2, d1, t1}, 8'h00);
    repeat (3) begin
      @(posedge CLK);
      #1;
      chk("mid_reset_hold", {6'b0, d20, t20}, 8'h00);
    end

    @(negedge CLK);
    RST = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #1;
      if (k == 9)  chk("rerun_k9",  {6'b0, d20, t20}, 8'h00);
      if (k == 10) chk("rerun_k10", {6'b0, d20, t20}, 8'h03);
    end
    @(posedge CLK);
    #1;
    chk("rerun_k11", {6'b0, d20, t20}, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
